// File: rtl/alu_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pipe
// Brief    : ALU control for the pipelined RV32 core. Decodes alu_op/funct3/
//            funct7 in ID into a 4-bit ALU select, registers it across the
//            ID/EX boundary and tracks multi-cycle MUL/DIV occupancy.
// Options  : ALU_CTRL_M_EXT_EN - enables M-extension decode and the
//            occupancy down-counter (otherwise busy is tied low).
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_pipe #(
  parameter int MD_LAT = 4,
  parameter int SEL_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             stall_in,
  input  logic             flush,
  output logic             id_ready,
  output logic             ex_valid,
  output logic [SEL_W-1:0] ex_sel,
  output logic             ex_muldiv,
  output logic             ex_done,
  output logic             ex_illegal,
  output logic             busy
);

  // Select encodings
  localparam logic [SEL_W-1:0] c_SEL_AND  = 4'b0000;
  localparam logic [SEL_W-1:0] c_SEL_OR   = 4'b0001;
  localparam logic [SEL_W-1:0] c_SEL_ADD  = 4'b0010;
  localparam logic [SEL_W-1:0] c_SEL_XOR  = 4'b0011;
  localparam logic [SEL_W-1:0] c_SEL_SLL  = 4'b0100;
  localparam logic [SEL_W-1:0] c_SEL_SRL  = 4'b0101;
  localparam logic [SEL_W-1:0] c_SEL_SUB  = 4'b0110;
  localparam logic [SEL_W-1:0] c_SEL_SRA  = 4'b0111;
  localparam logic [SEL_W-1:0] c_SEL_SLT  = 4'b1000;
  localparam logic [SEL_W-1:0] c_SEL_SLTU = 4'b1001;
`ifdef ALU_CTRL_M_EXT_EN
  localparam logic [SEL_W-1:0] c_SEL_MUL  = 4'b1010;
  localparam logic [SEL_W-1:0] c_SEL_MULH = 4'b1011;
  localparam logic [SEL_W-1:0] c_SEL_DIV  = 4'b1100;
  localparam logic [SEL_W-1:0] c_SEL_DIVU = 4'b1101;
  localparam logic [SEL_W-1:0] c_SEL_REM  = 4'b1110;
  localparam logic [SEL_W-1:0] c_SEL_REMU = 4'b1111;
  localparam logic [6:0]       c_F7_MULDIV = 7'b0000001;
  localparam logic [3:0]       c_MD_LOAD   = 4'(MD_LAT - 1);
`endif

  localparam logic [6:0] c_F7_BASE = 7'b0000000;
  localparam logic [6:0] c_F7_ALT  = 7'b0100000;

  // Elaboration-time parameter sanity
  generate
    if (SEL_W != 4) begin : g_sel_w_bad
      $error("alu_ctrl_pipe: SEL_W must be 4");
    end
    if ((MD_LAT < 1) || (MD_LAT > 15)) begin : g_md_lat_bad
      $error("alu_ctrl_pipe: MD_LAT must be in 1..15");
    end
  endgenerate

  logic [SEL_W-1:0] w_base_sel;
  logic [SEL_W-1:0] w_sel;
  logic             w_illegal;
  logic             w_muldiv;
  logic             w_cnt_zero;
  logic             w_accept;

  logic             r_ex_valid;
  logic [SEL_W-1:0] r_ex_sel;
  logic             r_ex_muldiv;
  logic             r_ex_illegal;

  // Base integer op selected by funct3 (shared by R-type and I-type)
  always_comb begin
    w_base_sel = c_SEL_ADD;
    case (funct3)
      3'b000:  w_base_sel = c_SEL_ADD;
      3'b001:  w_base_sel = c_SEL_SLL;
      3'b010:  w_base_sel = c_SEL_SLT;
      3'b011:  w_base_sel = c_SEL_SLTU;
      3'b100:  w_base_sel = c_SEL_XOR;
      3'b101:  w_base_sel = c_SEL_SRL;
      3'b110:  w_base_sel = c_SEL_OR;
      default: w_base_sel = c_SEL_AND;
    endcase
  end

  // Full decode; illegal encodings fall back to ADD with the illegal flag set
  always_comb begin
    w_sel     = c_SEL_ADD;
    w_illegal = 1'b0;
    w_muldiv  = 1'b0;
    case (alu_op)
      2'b00: w_sel = c_SEL_ADD;
      2'b01: w_sel = c_SEL_SUB;
      2'b10: begin
        if (funct7 == c_F7_BASE) begin
          w_sel = w_base_sel;
        end else if (funct7 == c_F7_ALT) begin
          if (funct3 == 3'b000)      w_sel = c_SEL_SUB;
          else if (funct3 == 3'b101) w_sel = c_SEL_SRA;
          else                       w_illegal = 1'b1;
        end
`ifdef ALU_CTRL_M_EXT_EN
        else if (funct7 == c_F7_MULDIV) begin
          w_muldiv = 1'b1;
          case (funct3)
            3'b000:  w_sel = c_SEL_MUL;
            3'b100:  w_sel = c_SEL_DIV;
            3'b101:  w_sel = c_SEL_DIVU;
            3'b110:  w_sel = c_SEL_REM;
            3'b111:  w_sel = c_SEL_REMU;
            // MULH/MULHSU/MULHU share one select; signedness comes from funct3 downstream
            default: w_sel = c_SEL_MULH;
          endcase
        end
`endif
        else begin
          w_illegal = 1'b1;
        end
      end
      default: begin
        // I-type: funct7 only matters as the shift-type field
        if (funct3 == 3'b001) begin
          if (funct7 == c_F7_BASE) w_sel = c_SEL_SLL;
          else                     w_illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == c_F7_BASE)     w_sel = c_SEL_SRL;
          else if (funct7 == c_F7_ALT) w_sel = c_SEL_SRA;
          else                         w_illegal = 1'b1;
        end else begin
          w_sel = w_base_sel;
        end
      end
    endcase
  end

`ifdef ALU_CTRL_M_EXT_EN
  logic [3:0] r_cnt;

  assign w_cnt_zero = (r_cnt == 4'd0);

  // Occupancy counter: loads on MUL/DIV accept, drains unless MEM holds
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (flush) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= w_muldiv ? c_MD_LOAD : 4'd0;
    end else if (!w_cnt_zero && !stall_in) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end
`else
  assign w_cnt_zero = 1'b1;
`endif

  assign id_ready = !stall_in && w_cnt_zero;
  assign w_accept = id_valid && id_ready;

  // ID/EX register: flush beats accept; idle-ready cycles insert a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_sel     <= c_SEL_ADD;
      r_ex_muldiv  <= 1'b0;
      r_ex_illegal <= 1'b0;
    end else if (flush) begin
      r_ex_valid   <= 1'b0;
      r_ex_muldiv  <= 1'b0;
      r_ex_illegal <= 1'b0;
    end else if (w_accept) begin
      r_ex_valid   <= 1'b1;
      r_ex_sel     <= w_sel;
      r_ex_muldiv  <= w_muldiv;
      r_ex_illegal <= w_illegal;
    end else if (id_ready) begin
      r_ex_valid   <= 1'b0;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_sel     = r_ex_sel;
  assign ex_muldiv  = r_ex_muldiv;
  assign ex_illegal = r_ex_illegal;
  assign ex_done    = r_ex_valid && w_cnt_zero;
  assign busy       = !w_cnt_zero;

endmodule
`default_nettype wire

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
- Next-generation ALU control for the pipelined RV32 core.
- Decodes ALUop, funct3 and funct7 in ID into a 4-bit ALU select code covering full RV32I and, optionally, the M extension.
- Registers the result into the ID/EX boundary and tracks multi-cycle MUL/DIV occupancy with a down-counter.
- Back-pressures ID via id_ready; the hazard unit consumes busy to stall IF/ID.

Parameters:
- MD_LAT, 4: EX occupancy in cycles for MUL/DIV class ops; legal range 1..15.
- SEL_W, 4: select width; must be 4. Any other value is a synthesis-time error.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- alu_op  in  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type ALU
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- stall_in  in  1  downstream (MEM) hold
- flush  in  1  kill EX contents (branch mispredict)
- id_ready  out  1  stage accepts this cycle
- ex_valid  out  1  EX holds an op
- ex_sel  out  SEL_W  registered ALU select
- ex_muldiv  out  1  EX op is MUL/DIV class
- ex_done  out  1  ex_valid and result final this cycle
- ex_illegal  out  1  EX op decoded illegal
- busy  out  1  multi-cycle op in progress (cnt != 0)

Behaviour:
- Select codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111
  - SLT 1000, SLTU 1001, MUL 1010, MULH 1011, DIV 1100, DIVU 1101, REM 1110, REMU 1111
  - MULHSU and MULHU map to MULH; the datapath resolves signedness from its own funct3 copy.
- Decode (combinational, internal):
  - alu_op 00 -> ADD; alu_op 01 -> SUB.
  - alu_op 10:
    - funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - funct7 0100000: only funct3 000 SUB and 101 SRA are legal.
    - funct7 0000001: MUL class (see Optional Feature).
    - Any other funct7/funct3 combination is illegal.
  - alu_op 11:
    - funct7 is ignored except for shifts.
    - funct3 001 requires funct7 0000000.
    - funct3 101 requires funct7 0000000 (SRL) or 0100000 (SRA).
    - All other funct3 values decode as in R-type.
  - Illegal decode -> sel ADD, illegal=1, muldiv=0.
- id_ready = !stall_in && (cnt == 0). Combinational; no dependence on id_valid.
- Update priority each cycle, highest first:
  1. rst: ex_valid=0, ex_sel=0010, ex_muldiv=0, ex_illegal=0, cnt=0.
  2. flush: ex_valid=0, cnt=0, ex_muldiv=0, ex_illegal=0; ex_sel unchanged. Flush overrides stall_in and a simultaneous accept; the ID instruction is discarded.
  3. accept (id_valid && id_ready): ex_valid=1; ex_sel/ex_muldiv/ex_illegal take the decode; cnt = muldiv ? MD_LAT-1 : 0.
  4. id_ready && !id_valid: ex_valid=0 (bubble); other fields hold.
  5. cnt != 0 && !stall_in: cnt decrements; all else holds.
  6. stall_in: everything holds, including cnt.
- ex_done = ex_valid && cnt == 0.
- busy = (cnt != 0).
- Latency:
  - Single-cycle ops appear on ex_* exactly 1 cycle after acceptance.
  - MUL/DIV: ex_done rises MD_LAT-1 cycles after ex_valid rises.
  - MD_LAT=1 behaves identically to a single-cycle op.
- Back-to-back: a new op can be accepted in the same cycle ex_done is high (cnt==0), giving zero bubbles between ops.
- Counter width: 4 bits; counts down, never wraps below 0.

Optional Feature:
- Macro: ALU_CTRL_M_EXT_EN.
- Defined: funct7 0000001 with alu_op 10 decodes to:
  - funct3 000 MUL; 001/010/011 MULH
  - funct3 100 DIV, 101 DIVU, 110 REM, 111 REMU
  - ex_muldiv=1 and cnt loads MD_LAT-1.
- Undefined:
  - funct7 0000001 is illegal.
  - ex_muldiv is tied 0; cnt logic is removed; busy is tied 0.
  - id_ready = !stall_in.

Test Plan:
- Reset: assert rst 2 cycles with id_valid=1 -> ex_valid=0, ex_sel=0010, busy=0, id_ready=1 after release.
- R-type sweep: alu_op=10, funct7=0100000, funct3=101 -> next cycle ex_sel=0111, ex_illegal=0. Same with funct3=111 -> ex_sel=0010, ex_illegal=1.
- I-type shift: alu_op=11, funct3=001, funct7=0100000 -> ex_illegal=1. With funct3=000 and funct7=1111111 -> ex_sel=0010, ex_illegal=0.
- M_EXT_EN, MD_LAT=4: DIVU (funct7=0000001, funct3=101) accepted at cycle t. Required:
  - ex_sel=1101, busy=1, id_ready=0 for cycles t+1..t+3
  - ex_done=1 at t+4
  - a queued ADD is accepted at t+4 and appears at t+5
- Stall during MUL: stall_in=1 for 2 cycles at t+2 -> cnt frozen; ex_done moves to t+6.
- Flush mid-DIV at t+2 with id_valid=1 -> at t+3 ex_valid=0, busy=0, id_ready=1; the flushed-cycle instruction does not appear in EX.
